// File: rtl/mdu_unit.sv
// ============================================================================
// mdu_unit -- execute-stage multiply/divide unit owning the HI/LO registers.
// Optional multiply-accumulate ops (9-12) are enabled by defining MDU_MADD_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_res
);

  localparam logic [3:0] C_OP_MULT  = 4'd1;
  localparam logic [3:0] C_OP_MULTU = 4'd2;
  localparam logic [3:0] C_OP_DIV   = 4'd3;
  localparam logic [3:0] C_OP_DIVU  = 4'd4;
  localparam logic [3:0] C_OP_MFHI  = 4'd5;
  localparam logic [3:0] C_OP_MFLO  = 4'd6;
  localparam logic [3:0] C_OP_MTHI  = 4'd7;
  localparam logic [3:0] C_OP_MTLO  = 4'd8;
  localparam logic [3:0] C_OP_MADD  = 4'd9;
  localparam logic [3:0] C_OP_MADDU = 4'd10;
  localparam logic [3:0] C_OP_MSUB  = 4'd11;
  localparam logic [3:0] C_OP_MSUBU = 4'd12;

  localparam int C_MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int C_CW   = $clog2(C_MAXC + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          state_q;
  logic [C_CW-1:0] cnt_q;
  logic [3:0]      op_q;
  logic [31:0]     opa_q;
  logic [31:0]     opb_q;
  logic [31:0]     hi_q;
  logic [31:0]     lo_q;

  logic            w_is_mult;
  logic            w_is_div;
  logic            w_signed;
  logic [63:0]     w_ext_a;
  logic [63:0]     w_ext_b;
  logic [63:0]     w_prod;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [31:0]     w_mag_a;
  logic [31:0]     w_mag_b;
  logic [31:0]     w_uq;
  logic [31:0]     w_ur;
  logic [63:0]     w_acc;
  logic            wr_d;
  logic [31:0]     hi_d;
  logic [31:0]     lo_d;

  // Issue decode on the live op; accumulate ops only exist when enabled.
  always_comb begin
    w_is_mult = (op == C_OP_MULT) || (op == C_OP_MULTU);
`ifdef MDU_MADD_EN
    w_is_mult = w_is_mult || (op == C_OP_MADD) || (op == C_OP_MADDU) ||
                (op == C_OP_MSUB) || (op == C_OP_MSUBU);
`endif
    w_is_div  = (op == C_OP_DIV) || (op == C_OP_DIVU);
  end

  // Completion datapath, evaluated from the latched operands and live HI/LO.
  always_comb begin
    w_signed = (op_q == C_OP_MULT) || (op_q == C_OP_DIV) ||
               (op_q == C_OP_MADD) || (op_q == C_OP_MSUB);
    w_ext_a  = w_signed ? {{32{opa_q[31]}}, opa_q} : {32'h0, opa_q};
    w_ext_b  = w_signed ? {{32{opb_q[31]}}, opb_q} : {32'h0, opb_q};
    w_prod   = w_ext_a * w_ext_b;
    w_acc    = {hi_q, lo_q};

    // Sign-magnitude division: 0x80000000 / -1 falls out as 0x80000000 rem 0.
    w_neg_a  = w_signed && opa_q[31];
    w_neg_b  = w_signed && opb_q[31];
    w_mag_a  = w_neg_a ? (~opa_q + 32'd1) : opa_q;
    w_mag_b  = w_neg_b ? (~opb_q + 32'd1) : opb_q;
    w_uq     = (w_mag_b == 32'd0) ? 32'd0 : (w_mag_a / w_mag_b);
    w_ur     = (w_mag_b == 32'd0) ? 32'd0 : (w_mag_a % w_mag_b);

    wr_d = 1'b0;
    hi_d = hi_q;
    lo_d = lo_q;
    case (op_q)
      C_OP_MULT, C_OP_MULTU: begin
        wr_d         = 1'b1;
        {hi_d, lo_d} = w_prod;
      end
      C_OP_DIV, C_OP_DIVU: begin
        wr_d = (opb_q != 32'd0);
        lo_d = (w_neg_a ^ w_neg_b) ? (~w_uq + 32'd1) : w_uq;
        hi_d = w_neg_a ? (~w_ur + 32'd1) : w_ur;
      end
      C_OP_MADD, C_OP_MADDU: begin
        wr_d         = 1'b1;
        {hi_d, lo_d} = w_acc + w_prod;
      end
      C_OP_MSUB, C_OP_MSUBU: begin
        wr_d         = 1'b1;
        {hi_d, lo_d} = w_acc - w_prod;
      end
      default: wr_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 4'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (w_is_mult || w_is_div) begin
              op_q    <= op;
              opa_q   <= rs_val;
              opb_q   <= rt_val;
              cnt_q   <= w_is_div ? C_CW'(DIV_CYCLES) : C_CW'(MULT_CYCLES);
              state_q <= S_RUN;
            end else if (op == C_OP_MTHI) begin
              hi_q <= rs_val;
            end else if (op == C_OP_MTLO) begin
              lo_q <= rs_val;
            end
          end
        end
        S_RUN: begin
          if (cnt_q == C_CW'(1)) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            if (wr_d) begin
              hi_q <= hi_d;
              lo_q <= lo_d;
            end
          end else begin
            cnt_q <= cnt_q - C_CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state_q == S_RUN);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign mdu_res = (op == C_OP_MFHI) ? hi_q :
                   (op == C_OP_MFLO) ? lo_q : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_mdu_unit.sv
// ============================================================================
// tb_mdu_unit -- self-checking bench for mdu_unit against a HI/LO reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_res;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo), .mdu_res(mdu_res)
  );

  always #5 clk = ~clk;

`ifdef MDU_MADD_EN
  localparam bit MADD_ON = 1'b1;
`else
  localparam bit MADD_ON = 1'b0;
`endif

  // Architectural effect of one op on HI/LO, in plain 64-bit arithmetic.
  function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sp, q, r;
    logic [63:0] up, acc;
    sp  = longint'($signed(a)) * longint'($signed(b));
    up  = {32'h0, a} * {32'h0, b};
    acc = {m_hi, m_lo};
    case (o)
      4'd1: {m_hi, m_lo} = sp;
      4'd2: {m_hi, m_lo} = up;
      4'd3: if (b != 0) begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      4'd4: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      4'd7: m_hi = a;
      4'd8: m_lo = a;
      4'd9:  if (MADD_ON) {m_hi, m_lo} = acc + sp;
      4'd10: if (MADD_ON) {m_hi, m_lo} = acc + up;
      4'd11: if (MADD_ON) {m_hi, m_lo} = acc - sp;
      4'd12: if (MADD_ON) {m_hi, m_lo} = acc - up;
      default: ;
    endcase
  endfunction

  function automatic int exp_busy(input logic [3:0] o);
    if (o == 4'd1 || o == 4'd2) return 5;
    if (o == 4'd3 || o == 4'd4) return 10;
    if (o >= 4'd9 && o <= 4'd12) return MADD_ON ? 5 : 0;
    return 0;
  endfunction

  // Issues one op at the current negedge, then counts busy cycles until idle.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int nbusy);
    req = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    req = 1'b0; op = 4'd0;
    nbusy = 0;
    while (busy && nbusy < 100) begin
      nbusy++;
      @(negedge clk);
    end
    model(o, a, b);
  endtask

  task automatic test_reset;
    reset = 1'b0; op = 4'd5;
    @(negedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %h want 0", busy); end
    n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
    n_vec++; if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
    n_vec++; if (mdu_res !== 32'd0) begin n_err++; $display("FAIL reset_res got %h want 0", mdu_res); end
    op = 4'd0;
    @(negedge clk);
    reset = 1'b1;
    m_hi = 0; m_lo = 0;
  endtask

  task automatic test_plan_vectors;
    int nb;
    do_op(4'd1, 32'hFFFFFFFD, 32'd5, nb);
    n_vec++; if (nb !== 5) begin n_err++; $display("FAIL mult_busy got %0d want 5", nb); end
    n_vec++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin n_err++; $display("FAIL mult_res got %h_%h want ffffffff_fffffff1", hi, lo); end
    do_op(4'd2, 32'hFFFFFFFD, 32'd5, nb);
    n_vec++; if ({hi, lo} !== 64'h00000004_FFFFFFF1) begin n_err++; $display("FAIL multu_res got %h_%h want 00000004_fffffff1", hi, lo); end
    do_op(4'd3, 32'hFFFFFFF9, 32'd2, nb);
    n_vec++; if (nb !== 10) begin n_err++; $display("FAIL div_busy got %0d want 10", nb); end
    n_vec++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin n_err++; $display("FAIL div_res got %h_%h want ffffffff_fffffffd", hi, lo); end
    do_op(4'd4, 32'd7, 32'd2, nb);
    n_vec++; if ({hi, lo} !== 64'h00000001_00000003) begin n_err++; $display("FAIL divu_res got %h_%h want 00000001_00000003", hi, lo); end
    do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, nb);
    n_vec++; if ({hi, lo} !== 64'h00000000_80000000) begin n_err++; $display("FAIL div_ovf got %h_%h want 00000000_80000000", hi, lo); end
  endtask

  task automatic test_move;
    int nb;
    req = 1'b1; op = 4'd8; rs_val = 32'h1234;
    @(negedge clk);
    n_vec++; if (lo !== 32'h1234) begin n_err++; $display("FAIL mtlo got %h want 1234", lo); end
    op = 4'd7; rs_val = 32'h5678;
    @(negedge clk);
    n_vec++; if (hi !== 32'h5678) begin n_err++; $display("FAIL mthi got %h want 5678", hi); end
    m_lo = 32'h1234; m_hi = 32'h5678;
    op = 4'd6; #1;
    n_vec++; if (mdu_res !== 32'h1234) begin n_err++; $display("FAIL mflo got %h want 1234", mdu_res); end
    @(negedge clk);
    op = 4'd5; #1;
    n_vec++; if (mdu_res !== 32'h5678) begin n_err++; $display("FAIL mfhi got %h want 5678", mdu_res); end
    @(negedge clk);
    op = 4'd1; #1;
    n_vec++; if (mdu_res !== 32'd0) begin n_err++; $display("FAIL res_other got %h want 0", mdu_res); end
    req = 1'b0; op = 4'd0;
    @(negedge clk);
    do_op(4'd3, 32'd99, 32'd0, nb);
    n_vec++; if (nb !== 10) begin n_err++; $display("FAIL div0_busy got %0d want 10", nb); end
    n_vec++; if ({hi, lo} !== {m_hi, m_lo} || lo !== 32'h1234) begin n_err++; $display("FAIL div0_res got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_run_ignored;
    int k;
    req = 1'b1; op = 4'd1; rs_val = 32'h00012345; rt_val = 32'h00067890;
    @(negedge clk);
    req = 1'b0; op = 4'd0;
    k = 0;
    while (busy && k < 100) begin
      k++;
      if (k == 3) begin req = 1'b1; op = 4'd7; rs_val = 32'hAAAA; end
      else begin req = 1'b0; op = 4'd0; end
      @(negedge clk);
    end
    req = 1'b0; op = 4'd0;
    model(4'd1, 32'h00012345, 32'h00067890);
    n_vec++; if (k !== 5) begin n_err++; $display("FAIL ign_busy got %0d want 5", k); end
    n_vec++; if ({hi, lo} !== {m_hi, m_lo}) begin n_err++; $display("FAIL ign_res got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_reset_mid;
    int nb, k;
    req = 1'b1; op = 4'd7; rs_val = 32'hDEAD0001;
    @(negedge clk);
    op = 4'd3; rs_val = 32'd1000; rt_val = 32'd7;
    @(negedge clk);
    req = 1'b0; op = 4'd0;
    k = 1;
    while (k < 4) begin k++; @(negedge clk); end
    reset = 1'b0; #1;
    n_vec++; if ({busy, hi, lo} !== 65'd0) begin n_err++; $display("FAIL rst_mid got busy=%h %h_%h want all 0", busy, hi, lo); end
    @(negedge clk);
    reset = 1'b1;
    m_hi = 0; m_lo = 0;
    do_op(4'd1, 32'd2, 32'd3, nb);
    n_vec++; if (nb !== 5 || lo !== 32'd6 || hi !== 32'd0) begin n_err++; $display("FAIL post_rst got busy=%0d %h_%h want 5 00000000_00000006", nb, hi, lo); end
  endtask

  task automatic test_madd;
    int nb;
    req = 1'b1; op = 4'd7; rs_val = 32'd0;
    @(negedge clk);
    op = 4'd8; rs_val = 32'hFFFFFFFF;
    @(negedge clk);
    req = 1'b0; op = 4'd0;
    m_hi = 0; m_lo = 32'hFFFFFFFF;
    do_op(4'd10, 32'd1, 32'd1, nb);
    n_vec++; if (nb !== exp_busy(4'd10)) begin n_err++; $display("FAIL maddu_busy got %0d want %0d", nb, exp_busy(4'd10)); end
    n_vec++; if ({hi, lo} !== (MADD_ON ? 64'h00000001_00000000 : 64'h00000000_FFFFFFFF)) begin n_err++; $display("FAIL maddu_res got %h_%h", hi, lo); end
  endtask

  task automatic test_random;
    logic [3:0] ops [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
    logic [3:0] o;
    logic [31:0] a, b;
    int nb, sel;
    for (int i = 0; i < 40; i++) begin
      o = ops[$urandom_range(0, 9)];
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if (sel == 2) b = b & 32'hFF;
      do_op(o, a, b, nb);
      n_vec++; if (nb !== exp_busy(o) || {hi, lo} !== {m_hi, m_lo}) begin
        n_err++;
        $display("FAIL rand op=%0d a=%h b=%h got busy=%0d %h_%h want %0d %h_%h", o, a, b, nb, hi, lo, exp_busy(o), m_hi, m_lo);
      end
    end
  endtask

  task automatic test_back_to_back;
    int nb;
    do_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, nb);
    do_op(4'd4, 32'hFFFFFFFF, 32'd16, nb);
    n_vec++; if (nb !== 10 || {hi, lo} !== {m_hi, m_lo}) begin n_err++; $display("FAIL b2b got busy=%0d %h_%h want 10 %h_%h", nb, hi, lo, m_hi, m_lo); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_plan_vectors;
    test_move;
    test_run_ignored;
    test_reset_mid;
    test_madd;
    test_random;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mdu_unit.md
# mdu_unit

Execute-stage multiply/divide unit of the five-stage pipeline. It owns the HI/LO architectural registers and runs multi-cycle mult/div operations, asserting `busy` so the hazard unit can stall. It serves mfhi/mflo reads on `mdu_res`, which is carried in the EX/MEM register and reaches the memory stage as the `mlu_res` writeback source.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for any multiply-class op (≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (≥1).

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low; clears all state.
- `req`  in  1: the op on `op` is issued this cycle (EX instruction valid, not stalled).
- `op`  in  4: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU.
- `rs_val`  in  32: forwarded rs operand.
- `rt_val`  in  32: forwarded rt operand.
- `busy`  out  1: a multi-cycle op is in flight.
- `hi`  out  32: current HI.
- `lo`  out  32: current LO.
- `mdu_res`  out  32: HI for MFHI, LO for MFLO, else 0; combinational, independent of `req`.

## Operation
- State machine: IDLE, RUN. Down-counter `cnt` sized to max(MULT_CYCLES, DIV_CYCLES).
- IDLE + `req` + multi-cycle op (1–4, 9–12):
  - Latch operands and op.
  - Load `cnt` with the op's cycle count.
  - Go to RUN.
- RUN:
  - Decrement `cnt` each cycle.
  - When `cnt` reaches 1, write the result to HI/LO on that edge and return to IDLE.
- IDLE + `req` + MTHI/MTLO: HI or LO ← `rs_val` on that edge; no busy.
- `req` while in RUN is ignored entirely: no write and no restart. The hazard unit must stall on `busy` or on a multi-cycle `req`.
- Arithmetic:
  - MULT: signed 32×32→64. MULTU: unsigned. {HI,LO} = product.
  - DIV: signed. LO = quotient, truncated toward zero. HI = remainder, with the dividend's sign.
  - DIVU: unsigned.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0: HI/LO unchanged, but the full DIV_CYCLES busy period still occurs.
  - MADD/MSUB (signed) and MADDU/MSUBU (unsigned): {HI,LO} ± product, modulo 2^64.
  - The accumulator value is sampled at completion, not at issue.
- `reset` low at any time (including mid-RUN):
  - Immediately busy=0, HI=0, LO=0, state=IDLE, `cnt`=0.
  - The in-flight result is discarded.

## Timing
- Multi-cycle `req` in cycle T:
  - `busy`=1 in cycles T+1 … T+N (N = MULT_CYCLES or DIV_CYCLES).
  - HI/LO hold new values from cycle T+N+1.
  - `busy`=0 in cycle T+N+1.
- A new multi-cycle `req` is accepted in cycle T+N+1, back-to-back.
- MTHI/MTLO in cycle T: visible on `hi`/`lo`/`mdu_res` in T+1.
- MFHI/MFLO: `mdu_res` reflects the HI/LO register value in the same cycle. No internal bypass of a same-cycle MTHI/MTLO.
- Reset values: `busy`=0, `hi`=0, `lo`=0, `mdu_res`=0.

## Configuration
- `MDU_MADD_EN`:
  - Defined: ops 9–12 are implemented as above, with MULT_CYCLES latency.
  - Undefined: ops 9–12 are treated as NONE. No busy, no HI/LO change, and `mdu_res`=0.

## Test plan
- `req` MULT, rs=0xFFFFFFFD, rt=5 → `busy`=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1. Same operands with MULTU → HI=0x00000004, LO=0xFFFFFFF1.
- `req` DIV, rs=0xFFFFFFF9 (−7), rt=2 → 10 busy cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- MTLO rs=0x1234 then MTHI rs=0x5678 in consecutive cycles; then MFLO/MFHI → `mdu_res`=0x1234, then 0x5678. DIV with rt=0 → HI/LO unchanged after 10 busy cycles.
- `req` MTHI rs=0xAAAA during cycle 3 of a MULT → ignored; HI equals the product's high word and the busy length is unchanged.
- Pull `reset` low in busy cycle 4 of a DIV → `busy`, HI and LO are 0 immediately. After release, a new MULT 2×3 gives LO=6 after 5 cycles.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, then MADDU 1×1 → HI=1, LO=0. Without the macro, the same op leaves HI=0, LO=0xFFFFFFFF and `busy` stays 0.
